serial_add_ctrl: RTL and testbench

Bit-serial addition controller that sequences a single one-bit adder slice over multi-bit operands. The slice is two half adders (a^b / a&b) plus an OR for carry merge. The block accepts two WIDTH-bit operands on a start strobe and steps the slice LSB-first, one bit per clock. It then presents the WIDTH-bit result and final carry with a one-cycle done pulse. It is the area-minimal adder path for low-throughput arithmetic, trading WIDTH+2 cycles per operation for one adder slice.

---
 rtl/serial_add_ctrl.sv | 112 +++++++++++
 tb/tb_serial_add_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice stepped LSB-first.
// Define SERIAL_ADD_SUB_EN to add the sub port (two's-complement subtract).
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             sub_in;
  logic             s1, c1, s, c2, c_next;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // Two half adders plus carry merge
  assign s1     = a_q[0] ^ b_q[0];
  assign c1     = a_q[0] & b_q[0];
  assign s      = s1 ^ c_q;
  assign c2     = s1 & c_q;
  assign c_next = c1 | c2;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b ^ {WIDTH{sub_in}};
          c_d     = sub_in;
          res_d   = '0;
          cout_d  = 1'b0;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        res_d = {s, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = c_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          cout_d  = c_next;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
    end
  end

  assign busy      = (state_q == ADD);
  assign done      = (state_q == DONE);
  assign result    = res_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) with a result scoreboard.
// Sub checks are built only when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         sub = 1'b0;
  logic         busy, done, carry_out;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_errors = 0;

  logic [W:0] sb_q[$];
  logic [W:0] exp_v;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .op_a(op_a),
    .op_b(op_b),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .busy(busy),
    .done(done),
    .result(result),
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input logic s);
    logic [W:0] r;
    if (s) r = {1'b0, a} + {1'b0, ~b} + 9'd1;
    else   r = {1'b0, a} + {1'b0, b};
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    op_a  = 8'h5A;
    op_b  = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, carry_out, result} !== {3'b000, 8'h00}) begin
        n_errors++;
        $display("FAIL reset[%0d]: busy=%b done=%b cout=%b res=%h, want 0",
                 i, busy, done, carry_out, result);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  // One complete op from IDLE, checked cycle by cycle.
  task automatic run_op(input string nm, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic s);
    logic [W:0] got;
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    sb_q.push_back(model(a, b, s));
    @(negedge clk);
    start = 1'b0;
    op_a  = ~a;
    op_b  = ~b;
    sub   = ~s;
    n_checks++;
    if ({result, carry_out} !== {8'h00, 1'b0}) begin
      n_errors++;
      $display("FAIL %s_clear: res=%h cout=%b, want 00 0",
               nm, result, carry_out);
    end
    for (int i = 0; i < W; i++) begin
      n_checks++;
      if ({busy, done} !== 2'b10) begin
        n_errors++;
        $display("FAIL %s_busy[%0d]: busy=%b done=%b, want 1 0",
                 nm, i, busy, done);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({busy, done} !== 2'b01) begin
      n_errors++;
      $display("FAIL %s_done: busy=%b done=%b, want 0 1", nm, busy, done);
    end
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s_sb: scoreboard empty", nm);
    end else begin
      exp_v = sb_q.pop_front();
      got   = {carry_out, result};
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL %s_result: cout,res=%h want %h", nm, got, exp_v);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({busy, done, carry_out, result} !== {2'b00, exp_v}) begin
      n_errors++;
      $display("FAIL %s_hold: busy=%b done=%b cout,res=%h want 0 0 %h",
               nm, busy, done, {carry_out, result}, exp_v);
    end
  endtask

  task automatic test_add();
    run_op("add_3c_45", 8'h3C, 8'h45, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
    run_op("add_80_80", 8'h80, 8'h80, 1'b0);
    run_op("add_a5_5a", 8'hA5, 8'h5A, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W:0] got;
    logic       exp_busy, exp_done;
    for (int c = 0; c < 40; c++) begin
      op_a  = W'($urandom);
      op_b  = W'($urandom);
      start = 1'b1;
      if (c % 10 == 0) sb_q.push_back(model(op_a, op_b, 1'b0));
      @(negedge clk);
      exp_busy = (c % 10) < 8;
      exp_done = (c % 10) == 8;
      n_checks++;
      if ({busy, done} !== {exp_busy, exp_done}) begin
        n_errors++;
        $display("FAIL b2b_ctl[%0d]: busy=%b done=%b want %b %b",
                 c, busy, done, exp_busy, exp_done);
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL b2b_sb[%0d]: scoreboard empty", c);
        end else begin
          exp_v = sb_q.pop_front();
          got   = {carry_out, result};
          n_checks++;
          if (got !== exp_v) begin
            n_errors++;
            $display("FAIL b2b_result[%0d]: cout,res=%h want %h",
                     c, got, exp_v);
          end
        end
      end
    end
    start = 1'b0;
    // Drain: the accept at cycle 40 was not issued, so flush to IDLE.
    for (int i = 0; i < 12; i++) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL b2b_left: %0d results never produced", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset_mid_op();
    op_a  = 8'hAA;
    op_b  = 8'h55;
    sub   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, carry_out, result} !== {3'b000, 8'h00}) begin
      n_errors++;
      $display("FAIL midrst_clear: busy=%b done=%b cout=%b res=%h, want 0",
               busy, done, carry_out, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done} !== 2'b00) begin
        n_errors++;
        $display("FAIL midrst_idle[%0d]: busy=%b done=%b want 0 0",
                 i, busy, done);
      end
    end
    run_op("after_rst", 8'h01, 8'h02, 1'b0);
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    run_op("sub_20_10", 8'h20, 8'h10, 1'b1);
    run_op("sub_10_20", 8'h10, 8'h20, 1'b1);
    run_op("sub_00_00", 8'h00, 8'h00, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_reset_mid_op();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
